regfile_port_arbiter: RTL and testbench

- Shares the single-write / dual-read register file between two requesters: the core datapath (writeback and operand reads) and a debug/loader port.
- Sits between the core, the debug unit and the register file. All register-file ports are driven from this block.
- The core has priority. A pending debug request is granted when the core is not writing, or unconditionally after MAX_WAIT cycles. When debug wins by timeout, the core is stalled for that cycle.
- Writes to x0 are suppressed for both requesters, because the register file does not hardwire x0.

---
 rtl/regfile_port_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: shares the single-write / dual-read register
// file between the core datapath and the debug/loader port. The core has
// priority; a waiting debug request is forced through after MAX_WAIT cycles
// of back-to-back core writes. Every debug grant costs the core one stall
// cycle, and writes to x0 are suppressed for both requesters.
module regfile_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reg_reset,
  input  logic [4:0]      core_a1,
  input  logic [4:0]      core_a2,
  input  logic            core_we,
  input  logic [4:0]      core_a3,
  input  logic [XLEN-1:0] core_wd,
  output logic            core_stall,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  output logic [4:0]      rf_a3,
  output logic            rf_we3,
  output logic [XLEN-1:0] rf_wd3,
  input  logic [XLEN-1:0] rf_rd1
);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT, ACK} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  // Set once a request has been accepted; cleared only after dbg_req is
  // seen low in IDLE, so a held-high request is not granted twice.
  logic              req_seen_q, req_seen_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [XLEN-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic              we_sel;

  // State and result registers, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge reg_reset) begin
    if (!reg_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_seen_q  <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_seen_q  <= req_seen_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Next-state logic: request qualification, wait counting and read capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_seen_d  = req_seen_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (!dbg_req) begin
          req_seen_d = 1'b0;
        end else if (!req_seen_q) begin
          req_seen_d = 1'b1;
          if (core_we) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = GRANT;
          end
        end
      end
      WAIT: begin
        if (!core_we || (cnt_q == MAX_WAIT_C)) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GRANT: begin
        if (!dbg_we) begin
          dbg_rdata_d = rf_rd1;
        end
        cnt_d     = '0;
        dbg_ack_d = 1'b1;
        state_d   = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port mux: debug owns read port 1 and the write port only during GRANT.
  always_comb begin
    rf_a1      = core_a1;
    rf_a2      = core_a2;
    rf_a3      = core_a3;
    rf_wd3     = core_wd;
    we_sel     = core_we & (core_a3 != 5'd0);
    core_stall = 1'b0;
    if (state_q == GRANT) begin
      rf_a1      = dbg_addr;
      rf_a3      = dbg_addr;
      rf_wd3     = dbg_wdata;
      we_sel     = dbg_we & (dbg_addr != 5'd0);
      core_stall = 1'b1;
    end
    // No register-file write may slip through while reset is held.
    rf_we3 = we_sel & reg_reset;
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed testbench for regfile_port_arbiter with a behavioural register
// file attached to the rf_* ports.
module tb_regfile_port_arbiter;

  logic        clk;
  logic        reg_reset;
  logic [4:0]  core_a1, core_a2, core_a3;
  logic        core_we;
  logic [31:0] core_wd;
  logic        core_stall;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [4:0]  rf_a1, rf_a2, rf_a3;
  logic        rf_we3;
  logic [31:0] rf_wd3;
  logic [31:0] rf_rd1;

  int tests_run = 0;
  int failed    = 0;
  int txn_cnt   = 0;
  int stall_cnt = 0;
  int x0_wr_cnt = 0;

  logic        rf_clr;
  logic [31:0] rf_mem [32];

  regfile_port_arbiter #(.MAX_WAIT(4), .XLEN(32)) dut (
    .clk(clk), .reg_reset(reg_reset),
    .core_a1(core_a1), .core_a2(core_a2), .core_we(core_we),
    .core_a3(core_a3), .core_wd(core_wd), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_we3(rf_we3),
    .rf_wd3(rf_wd3), .rf_rd1(rf_rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model (not reset, x0 not hardwired) plus port monitors.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
    end else if (rf_we3) begin
      rf_mem[rf_a3] <= rf_wd3;
    end
    if (rf_we3 && rf_a3 == 5'd0) x0_wr_cnt <= x0_wr_cnt + 1;
    if (core_stall) stall_cnt <= stall_cnt + 1;
  end
  assign rf_rd1 = rf_mem[rf_a1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One debug transaction from IDLE; exp_wait is the number of edges from
  // raising dbg_req to the GRANT cycle.
  task automatic dbg_txn(input string tag, input logic we, input logic [4:0] addr,
                         input logic [31:0] wd, input int exp_wait,
                         input logic [31:0] exp_rd, input logic hold);
    int n;
    n = 0;
    dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
    #1;
    check_val({tag, "_stall_pre"}, 32'(core_stall), 32'd0);
    do begin
      step();
      n++;
    end while (!core_stall && n < 20);
    check_val({tag, "_grant_cycle"}, n, exp_wait);
    if (n >= 20) begin
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
    end
    txn_cnt++;
    check_val({tag, "_rf_a1"}, 32'(rf_a1), 32'(addr));
    check_val({tag, "_rf_a3"}, 32'(rf_a3), 32'(addr));
    check_val({tag, "_rf_a2"}, 32'(rf_a2), 32'(core_a2));
    check_val({tag, "_rf_we3"}, 32'(rf_we3), 32'(we && addr != 5'd0));
    if (we) check_val({tag, "_rf_wd3"}, rf_wd3, wd);
    check_val({tag, "_ack_in_grant"}, 32'(dbg_ack), 32'd0);
    step();
    check_val({tag, "_ack"}, 32'(dbg_ack), 32'd1);
    check_val({tag, "_stall_ack"}, 32'(core_stall), 32'd0);
    if (!we) check_val({tag, "_rdata"}, dbg_rdata, exp_rd);
    if (!hold) begin
      dbg_req = 1'b0;
      step();
      check_val({tag, "_ack_drop"}, 32'(dbg_ack), 32'd0);
      step();
    end
  endtask

  initial begin
    reg_reset = 1'b0; rf_clr = 1'b1;
    core_a1 = 5'd1; core_a2 = 5'd9; core_a3 = 5'd4; core_we = 1'b1; core_wd = 32'h1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    step(); step();
    // Reset state; core write held high must not reach the register file.
    check_val("rst_ack", 32'(dbg_ack), 32'd0);
    check_val("rst_rdata", dbg_rdata, 32'd0);
    check_val("rst_stall", 32'(core_stall), 32'd0);
    check_val("rst_we3_forced", 32'(rf_we3), 32'd0);
    core_we = 1'b0; rf_clr = 1'b0;
    reg_reset = 1'b1;
    step();

    // 1: debug read of x5 with an idle core.
    dbg_txn("rd_x5_init", 1'b0, 5'd5, 32'd0, 1, 32'd0, 1'b0);

    // 2: core writes x5, debug reads it back.
    core_we = 1'b1; core_a3 = 5'd5; core_wd = 32'hDEADBEEF;
    #1;
    check_val("core_wr_x5_we3", 32'(rf_we3), 32'd1);
    step();
    core_we = 1'b0;
    dbg_txn("rd_x5", 1'b0, 5'd5, 32'd0, 1, 32'hDEADBEEF, 1'b0);

    // 3: core writes every cycle; debug write forced through by the timeout.
    core_we = 1'b1; core_a3 = 5'd3; core_wd = 32'h55;
    dbg_txn("wr_x7_forced", 1'b1, 5'd7, 32'h12345678, 5, 32'd0, 1'b0);
    core_we = 1'b0;
    step();
    dbg_txn("rd_x7", 1'b0, 5'd7, 32'd0, 1, 32'h12345678, 1'b0);

    // 4: writes to x0 from both sides are suppressed.
    dbg_txn("wr_x0", 1'b1, 5'd0, 32'hFFFFFFFF, 1, 32'd0, 1'b0);
    core_we = 1'b1; core_a3 = 5'd0; core_wd = 32'hAAAA;
    #1;
    check_val("core_wr_x0_we3", 32'(rf_we3), 32'd0);
    step();
    core_we = 1'b0;
    dbg_txn("rd_x0", 1'b0, 5'd0, 32'd0, 1, 32'd0, 1'b0);

    // 5: request held high across ack is not granted again.
    dbg_txn("rd_hold", 1'b0, 5'd7, 32'd0, 1, 32'h12345678, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("hold_no_stall", 32'(core_stall), 32'd0);
      check_val("hold_no_ack", 32'(dbg_ack), 32'd0);
    end
    dbg_req = 1'b0;
    step();
    dbg_txn("rd_rearm", 1'b0, 5'd5, 32'd0, 1, 32'hDEADBEEF, 1'b0);

    // 6: reset pulsed while the request waits behind core writes.
    core_we = 1'b1; core_a3 = 5'd3; core_wd = 32'h66; core_a1 = 5'd2;
    dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hCAFEF00D; dbg_req = 1'b1;
    step(); step();
    check_val("wait_stall", 32'(core_stall), 32'd0);
    reg_reset = 1'b0;
    #1;
    check_val("midrst_ack", 32'(dbg_ack), 32'd0);
    check_val("midrst_stall", 32'(core_stall), 32'd0);
    check_val("midrst_we3", 32'(rf_we3), 32'd0);
    check_val("midrst_idle_a1", 32'(rf_a1), 32'd2);
    step();
    dbg_req = 1'b0; core_we = 1'b0;
    reg_reset = 1'b1;
    step();
    dbg_txn("rd_x12_lost", 1'b0, 5'd12, 32'd0, 1, 32'd0, 1'b0);
    dbg_txn("wr_x12", 1'b1, 5'd12, 32'hCAFEF00D, 1, 32'd0, 1'b0);
    dbg_txn("rd_x12", 1'b0, 5'd12, 32'd0, 1, 32'hCAFEF00D, 1'b0);

    // Global: one stall per granted transaction, never a write to x0.
    check_val("stall_total", stall_cnt, txn_cnt);
    check_val("x0_writes", x0_wr_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
